cas_sort_seq: RTL and testbench

- Sequential odd-even transposition sorter. Accepts a burst of NUM_ELEM BITS-bit unsigned values over a valid/ready stream and sorts them in place, using the existing two-input compare-and-swap cell as its comparator.
- Emits the sorted values, largest first, on a second valid/ready stream.
- Sits directly downstream of the input binarisation stage. It is the consumer and orchestrator of the cas cell: pair-wise CAS becomes a full N-element sort.

---
 rtl/cas_sort_seq.sv | 211 +++++++++++++++++++++
 tb/tb_cas_sort_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_sort_seq.sv
// Sequential odd-even transposition sorter that drives floor(NUM_ELEM/2) cas_cell instances.
// Optional macro CAS_SORT_EARLY_EXIT_EN ends SORT after two consecutive swap-free phases.

module cas_cell #(
  parameter int unsigned BITS = 6
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic [BITS-1:0] o_max,
  output logic [BITS-1:0] o_min
);

  always_comb begin
    o_max = (i_b > i_a) ? i_b : i_a;
    o_min = (i_b > i_a) ? i_a : i_b;
  end

endmodule

module cas_sort_seq #(
  parameter int unsigned BITS     = 6,
  parameter int unsigned NUM_ELEM = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_ELEM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            busy
`ifdef CAS_SORT_EARLY_EXIT_EN
  ,
  output logic [IDX_W:0]  sort_cycles
`endif
);

  localparam int unsigned NumPairs = NUM_ELEM / 2;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e           r_state, w_state_d;
  logic [BITS-1:0]  r_buf [NUM_ELEM];
  logic [BITS-1:0]  w_buf_sorted [NUM_ELEM];
  logic [BITS-1:0]  w_a [NumPairs];
  logic [BITS-1:0]  w_b [NumPairs];
  logic [BITS-1:0]  w_max [NumPairs];
  logic [BITS-1:0]  w_min [NumPairs];
  logic [IDX_W-1:0] r_wr_idx, w_wr_idx_d;
  logic [IDX_W-1:0] r_rd_idx, w_rd_idx_d;
  logic [IDX_W-1:0] r_phase, w_phase_d;
  logic             r_started;
  logic             w_load_fire;
  logic             w_sort_done;
  logic             w_early_exit;

  // Operand muxing: even phase pairs (2k,2k+1), odd phase pairs (2k+1,2k+2).
  for (genvar k = 0; k < NumPairs; k++) begin : g_pair
    if (2 * k + 2 < NUM_ELEM) begin : g_shift
      assign w_a[k] = r_phase[0] ? r_buf[2*k+1] : r_buf[2*k];
      assign w_b[k] = r_phase[0] ? r_buf[2*k+2] : r_buf[2*k+1];
    end else begin : g_fixed
      assign w_a[k] = r_buf[2*k];
      assign w_b[k] = r_buf[2*k+1];
    end
    cas_cell #(.BITS(BITS)) u_cas (
      .i_a  (w_a[k]),
      .i_b  (w_b[k]),
      .o_max(w_max[k]),
      .o_min(w_min[k])
    );
  end

  // Per-element write-back; unpaired end elements keep their value.
  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_elem
    logic [BITS-1:0] w_even;
    logic [BITS-1:0] w_odd;
    if ((i % 2 == 0) && (i + 1 < NUM_ELEM)) begin : g_even_hi
      assign w_even = w_max[i/2];
    end else if (i % 2 == 1) begin : g_even_lo
      assign w_even = w_min[i/2];
    end else begin : g_even_hold
      assign w_even = r_buf[i];
    end
    if ((i % 2 == 1) && (i + 1 < NUM_ELEM)) begin : g_odd_hi
      assign w_odd = w_max[i/2];
    end else if ((i % 2 == 0) && (i >= 2)) begin : g_odd_lo
      assign w_odd = w_min[i/2-1];
    end else begin : g_odd_hold
      assign w_odd = r_buf[i];
    end
    assign w_buf_sorted[i] = r_phase[0] ? w_odd : w_even;
  end

`ifdef CAS_SORT_EARLY_EXIT_EN
  logic [NumPairs-1:0] w_swap;
  logic                w_swap_any;
  logic                r_clean;
  logic [IDX_W:0]      r_sort_cycles;

  // The last pair has no odd-phase partner when NUM_ELEM is even.
  for (genvar k = 0; k < NumPairs; k++) begin : g_swap
    if (2 * k + 2 < NUM_ELEM) begin : g_always
      assign w_swap[k] = (w_b[k] > w_a[k]);
    end else begin : g_even_only
      assign w_swap[k] = (w_b[k] > w_a[k]) && !r_phase[0];
    end
  end

  assign w_swap_any   = |w_swap;
  assign w_early_exit = r_clean && !w_swap_any;
  assign sort_cycles  = r_sort_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clean       <= 1'b0;
      r_sort_cycles <= '0;
    end else if (r_state == StSort) begin
      r_clean <= !w_swap_any;
      if (w_sort_done) begin
        r_sort_cycles <= {1'b0, r_phase} + {{IDX_W{1'b0}}, 1'b1};
      end
    end else begin
      r_clean <= 1'b0;
    end
  end
`else
  assign w_early_exit = 1'b0;
`endif

  assign in_ready    = r_started && (r_state == StLoad);
  assign w_load_fire = in_valid && in_ready;
  assign w_sort_done = (r_state == StSort) && ((r_phase == LastIdx) || w_early_exit);
  assign busy        = (r_state == StSort);
  assign out_valid   = (r_state == StDrain);
  assign out_last    = (r_state == StDrain) && (r_rd_idx == LastIdx);
  assign out_data    = (r_state == StDrain) ? r_buf[r_rd_idx] : '0;

  always_comb begin
    w_state_d  = r_state;
    w_wr_idx_d = r_wr_idx;
    w_rd_idx_d = r_rd_idx;
    w_phase_d  = r_phase;
    unique case (r_state)
      StLoad: begin
        if (w_load_fire) begin
          if (r_wr_idx == LastIdx) begin
            w_state_d  = StSort;
            w_wr_idx_d = '0;
            w_phase_d  = '0;
          end else begin
            w_wr_idx_d = r_wr_idx + IDX_W'(1);
          end
        end
      end
      StSort: begin
        if (w_sort_done) begin
          w_state_d  = StDrain;
          w_rd_idx_d = '0;
          w_phase_d  = '0;
        end else begin
          w_phase_d = r_phase + IDX_W'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (r_rd_idx == LastIdx) begin
            w_state_d  = StLoad;
            w_rd_idx_d = '0;
          end else begin
            w_rd_idx_d = r_rd_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StLoad;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_phase   <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_wr_idx  <= w_wr_idx_d;
      r_rd_idx  <= w_rd_idx_d;
      r_phase   <= w_phase_d;
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_load_fire) begin
      r_buf[r_wr_idx] <= in_data;
    end else if (r_state == StSort) begin
      r_buf <= w_buf_sorted;
    end
  end

endmodule

// File: tb/tb_cas_sort_seq.sv
// Directed and randomised bench for cas_sort_seq (8 x 6-bit); honours CAS_SORT_EARLY_EXIT_EN.

module tb_cas_sort_seq;

  localparam int BITS = 6;
  localparam int N    = 8;

  typedef logic [BITS-1:0] vec_t [N];

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] out_data;
  logic            out_last;
  logic            busy;
`ifdef CAS_SORT_EARLY_EXIT_EN
  logic [3:0]      sort_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cas_sort_seq #(.BITS(BITS), .NUM_ELEM(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
`ifdef CAS_SORT_EARLY_EXIT_EN
    .sort_cycles(sort_cycles),
`endif
    .busy     (busy)
  );

  function automatic vec_t sort_desc(input vec_t v);
    vec_t s = v;
    logic [BITS-1:0] t;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (s[j] > s[i]) begin
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
      end
    end
    return s;
  endfunction

  // Returns at the negedge after the last accept, with in_valid dropped.
  task automatic load_batch(input vec_t v, input int gap_pct, output bit to);
    int i = 0;
    int guard = 0;
    to = 1'b0;
    while (i < N) begin
      @(negedge clk);
      if (guard++ > 500) begin to = 1'b1; in_valid = 1'b0; return; end
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? v[i] : BITS'($urandom);
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_sort(output int bc, output bit to);
    int guard = 0;
    bc = 0;
    to = 1'b0;
    while (!out_valid) begin
      if (busy) bc++;
      if (guard++ > 100) begin to = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic drain_batch(input int gap_pct, output vec_t got, output logic [N-1:0] lasts,
                             output logic rdy_after, output bit mono_ok, output bit to);
    int j = 0;
    int guard = 0;
    got = '{default: '0};
    lasts = '0;
    mono_ok = 1'b1;
    to = 1'b0;
    rdy_after = 1'b0;
    while (j < N) begin
      if (guard++ > 500) begin to = 1'b1; out_ready = 1'b0; return; end
      out_ready = ($urandom_range(0, 99) >= gap_pct);
      if (out_valid && out_ready) begin
        got[j] = out_data;
        lasts[j] = out_last;
        if (j > 0 && out_data > got[j-1]) mono_ok = 1'b0;
        j++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    rdy_after = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  // Full batch with fixed expected output and expected SORT length.
  task automatic run_directed(input string name, input vec_t v, input vec_t exp, input int exp_bc,
                              input int vgap, input int rgap);
    vec_t got;
    logic [N-1:0] lasts;
    logic rdy;
    bit mono, to_l, to_s, to_d;
    int bc;
    load_batch(v, vgap, to_l);
    wait_sort(bc, to_s);
    checks++; if (bc != exp_bc || to_l || to_s) begin
      errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d timeout=%0b%0b", name, bc, exp_bc, to_l, to_s);
    end
    drain_batch(rgap, got, lasts, rdy, mono, to_d);
    for (int j = 0; j < N; j++) begin
      checks++; if (got[j] !== exp[j]) begin
        errors++; $display("FAIL %s out[%0d] got=%0d exp=%0d", name, j, got[j], exp[j]);
      end
    end
    checks++; if (lasts !== 8'h80 || to_d) begin
      errors++; $display("FAIL %s out_last got=%b exp=10000000 timeout=%0b", name, lasts, to_d);
    end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s ready_after got=%b exp=1", name, rdy); end
  endtask

  task automatic test_basic();
    run_directed("basic", '{5, 63, 0, 17, 17, 42, 1, 9}, '{63, 42, 17, 17, 9, 5, 1, 0}, 8, 0, 0);
  endtask

  task automatic test_backpressure();
    vec_t got;
    vec_t exp = '{63, 42, 17, 17, 9, 5, 1, 0};
    logic [N-1:0] lasts;
    logic rdy;
    bit mono, to_l, to_s, to_d;
    int bc;
    load_batch('{5, 63, 0, 17, 17, 42, 1, 9}, 0, to_l);
    wait_sort(bc, to_s);
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 6'd63 || out_last !== 1'b0) begin
        errors++; $display("FAIL stall%0d valid/data/last got=%b/%0d/%b exp=1/63/0",
                           k, out_valid, out_data, out_last);
      end
      @(negedge clk);
    end
    drain_batch(0, got, lasts, rdy, mono, to_d);
    for (int j = 0; j < N; j++) begin
      checks++; if (got[j] !== exp[j] || to_d) begin
        errors++; $display("FAIL stall_out[%0d] got=%0d exp=%0d", j, got[j], exp[j]);
      end
    end
  endtask

  task automatic test_worst_case();
    run_directed("ascending", '{0, 1, 2, 3, 4, 5, 6, 7}, '{7, 6, 5, 4, 3, 2, 1, 0}, 8, 20, 20);
  endtask

  task automatic test_early_exit();
`ifdef CAS_SORT_EARLY_EXIT_EN
    run_directed("presorted", '{60, 50, 40, 30, 20, 10, 5, 0}, '{60, 50, 40, 30, 20, 10, 5, 0},
                 2, 0, 0);
    checks++; if (sort_cycles !== 4'd2) begin
      errors++; $display("FAIL sort_cycles got=%0d exp=2", sort_cycles);
    end
`else
    run_directed("presorted", '{60, 50, 40, 30, 20, 10, 5, 0}, '{60, 50, 40, 30, 20, 10, 5, 0},
                 8, 0, 0);
`endif
  endtask

  task automatic test_reset_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 6'd63;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_load ready/busy/valid got=%b/%b/%b exp=0/0/0", in_ready, busy, out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_load_release got=%b exp=1", in_ready); end
    run_directed("after_rst_load", '{10, 20, 30, 40, 50, 60, 1, 2}, '{60, 50, 40, 30, 20, 10, 2, 1},
                 8, 0, 0);
  endtask

  task automatic test_reset_sort();
    bit to;
    load_batch('{9, 8, 7, 6, 5, 4, 3, 2}, 0, to);
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1 || to) begin errors++; $display("FAIL rst_sort_pre busy got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL rst_sort busy/valid/ready/data got=%b/%b/%b/%0d exp=0/0/0/0",
                         busy, out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_sort_release got=%b exp=1", in_ready); end
    run_directed("after_rst_sort", '{33, 3, 33, 12, 0, 63, 63, 7}, '{63, 63, 33, 33, 12, 7, 3, 0},
                 8, 0, 0);
  endtask

  task automatic test_random();
    vec_t v, exp, got;
    logic [N-1:0] lasts;
    logic rdy;
    bit mono, to_l, to_s, to_d, bad;
    int bc;
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
      exp = sort_desc(v);
      load_batch(v, 30, to_l);
      wait_sort(bc, to_s);
      drain_batch(30, got, lasts, rdy, mono, to_d);
      bad = to_l || to_s || to_d;
      for (int j = 0; j < N; j++) if (got[j] !== exp[j]) bad = 1'b1;
      checks++; if (bad) begin
        errors++; $display("FAIL random%0d got=%p exp=%p", b, got, exp);
      end
      checks++; if (!mono) begin errors++; $display("FAIL random%0d monotonic got=increase exp=none", b); end
      checks++; if (lasts !== 8'h80 || rdy !== 1'b1) begin
        errors++; $display("FAIL random%0d last/ready got=%b/%b exp=10000000/1", b, lasts, rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_worst_case();
    test_early_exit();
    test_reset_load();
    test_reset_sort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
